// File: rtl/gbpt_update_ctrl.sv
// GBPT update controller: arbitrates the single-ported 2-bit counter array
// between prediction lookups and queued branch-resolution read-modify-writes.
module gbpt_update_ctrl #(
  parameter int INDEX_WIDTH    = 12,
  parameter int UPDATE_Q_DEPTH = 4,
  parameter int STARVE_LIMIT   = 8
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   pred_valid,
  input  logic [INDEX_WIDTH-1:0] pred_index,
  output logic                   pred_ready,
  output logic                   pred_resp_valid,
  output logic                   pred_resp_taken,
  input  logic                   upd_valid,
  input  logic [INDEX_WIDTH-1:0] upd_index,
  input  logic                   upd_taken,
  output logic                   upd_ready,
  output logic                   array_en,
  output logic                   array_wr,
  output logic [INDEX_WIDTH-1:0] array_index,
  output logic [1:0]             array_wdata,
  input  logic [1:0]             array_rdata
);

  localparam int PTR_W = (UPDATE_Q_DEPTH > 1) ? $clog2(UPDATE_Q_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] WRITE   = 2'd2;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  logic [INDEX_WIDTH-1:0] q_index [UPDATE_Q_DEPTH];
  logic                   q_taken [UPDATE_Q_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       q_count;
  logic [1:0]             state, state_nxt;
  logic [STV_W-1:0]       starve_cnt;
  logic [1:0]             wdata_p1;
  logic                   resp_vld_p1;

  logic q_full, q_empty, force_upd, upd_op_rdy, pred_acc, upd_issue;
  logic enq, deq;

  assign q_full     = (q_count == CNT_W'(UPDATE_Q_DEPTH));
  assign q_empty    = (q_count == '0);
  assign force_upd  = (starve_cnt == STV_W'(STARVE_LIMIT));
  // An update needs the slot when a read is pending in IDLE or a write in WRITE.
  assign upd_op_rdy = ((state == IDLE) && !q_empty) || (state == WRITE);
  assign pred_ready = !(force_upd && upd_op_rdy);
  assign pred_acc   = pred_valid && pred_ready;
  // A forced update already blocked the prediction, so one rule covers both cases.
  assign upd_issue  = upd_op_rdy && !pred_acc;

  assign upd_ready  = !q_full;
  assign enq        = upd_valid && !q_full;
  assign deq        = upd_issue && (state == WRITE);

  // ---- stage 0: array slot request ----
  assign array_en    = upd_issue || pred_acc;
  assign array_wr    = upd_issue && (state == WRITE);
  assign array_index = upd_issue ? q_index[rd_ptr] : pred_index;
  assign array_wdata = wdata_p1;

  // ---- stage 1: array read data returns ----
  assign pred_resp_valid = resp_vld_p1;
  assign pred_resp_taken = array_rdata[1];

  // Queue storage is written on enqueue only; contents need no reset.
  always_ff @(posedge CLK) begin
    if (enq) begin
      q_index[wr_ptr] <= upd_index;
      q_taken[wr_ptr] <= upd_taken;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   q_count <= q_count + CNT_W'(1);
        2'b01:   q_count <= q_count - CNT_W'(1);
        default: q_count <= q_count;
      endcase
    end
  end

  // RMW sequencing: read head, latch new counter, write when granted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (upd_issue) state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = WRITE;
      WRITE:   if (upd_issue) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state, starvation counter and prediction response valid.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      resp_vld_p1 <= 1'b0;
    end else begin
      state       <= state_nxt;
      resp_vld_p1 <= pred_acc;
      if (upd_issue)
        starve_cnt <= '0;
      else if (upd_op_rdy && !force_upd)
        starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

  // New counter value is captured once in RD_WAIT and held through WRITE stalls.
  always_ff @(posedge CLK) begin
    if (state == RD_WAIT)
      wdata_p1 <= q_taken[rd_ptr] ? sat_inc(array_rdata) : sat_dec(array_rdata);
  end

endmodule
